// File: rtl/bday_rx_sched.sv
// rtl/bday_rx_sched.sv - two-requester serial pattern scheduler with frame-based hit accounting
//
// Purpose:
//   Arbitrates round-robin between two pattern requesters, serialises the
//   granted word MSB first onto o_bit_seq, then idles the line high for
//   GAP_BITS cycles. A free-running frame counter feeds the receiver and
//   marks when its hit count is latched for display and when the
//   per-requester hit counters clear.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req0_word/valid, o_req0_ready   requester 0 word handshake (ready = accept strobe)
//   i_req1_word/valid, o_req1_ready   requester 1 word handshake
//   o_bit_seq                     serial stream, idles at 1
//   o_count_for_rx                frame counter 0..FRAME_LEN-1
//   i_seq_detected                receiver detect, aligned with final pattern bit
//   i_seq_det_count               receiver hit count
//   o_disp_count, o_disp_valid    latched display count and its strobe
//   o_hits0, o_hits1              per-requester hits in the current frame
//   o_busy, o_active_req          stream in use / requester owning it
module bday_rx_sched #(
    parameter int WORD_W    = 9,
    parameter int GAP_BITS  = 2,
    parameter int FRAME_LEN = 1002
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WORD_W-1:0] i_req0_word,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [WORD_W-1:0] i_req1_word,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    output logic              o_bit_seq,
    output logic [9:0]        o_count_for_rx,
    input  logic              i_seq_detected,
    input  logic [5:0]        i_seq_det_count,
    output logic [5:0]        o_disp_count,
    output logic              o_disp_valid,
    output logic [7:0]        o_hits0,
    output logic [7:0]        o_hits1,
    output logic              o_busy,
    output logic              o_active_req
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [IW-1:0] BIT_MSB   = IW'(WORD_W - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);
    localparam logic [9:0]    CNT_LAST  = 10'(FRAME_LEN - 1);
    localparam logic [9:0]    CNT_LATCH = 10'(FRAME_LEN - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic [GW-1:0]     gap_cnt;
    logic              last_grant;
    logic              grant_any;
    logic              grant_sel;
    logic              accept;
    logic              lsb_hit;

    // Round-robin: on a tie the requester not served last wins; a lone
    // requester is always served.
    always_comb begin
        grant_any = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = i_req1_valid;
        end
    end

    // Reset masks the accept so no requester sees a ready for a word that
    // will never be sent.
    assign accept  = (state == S_IDLE) && grant_any && !i_rst;
    assign lsb_hit = (state == S_SHIFT) && (bit_idx == '0) && i_seq_detected;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_SHIFT;
            S_SHIFT: if (bit_idx == '0) state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_bit_seq    = 1'b1;
        o_busy       = 1'b0;
        case (state)
            S_IDLE: begin
                o_req0_ready = accept & ~grant_sel;
                o_req1_ready = accept & grant_sel;
            end
            S_SHIFT: begin
                o_bit_seq = shreg[WORD_W-1];
                o_busy    = 1'b1;
            end
            S_GAP: begin
                o_busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Word capture and serialisation; the shift register holds a private
    // copy so requester word changes after accept cannot leak in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg        <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            last_grant   <= 1'b1;
            o_active_req <= 1'b0;
        end else begin
            if (accept) begin
                shreg        <= grant_sel ? i_req1_word : i_req0_word;
                bit_idx      <= BIT_MSB;
                last_grant   <= grant_sel;
                o_active_req <= grant_sel;
            end else if (state == S_SHIFT) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx - IW'(1);
            end
            if (state == S_SHIFT) begin
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    assign o_disp_valid = (o_count_for_rx == CNT_LATCH);

    // Frame counter runs regardless of the stream; a word in flight simply
    // straddles the wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count_for_rx <= '0;
            o_disp_count   <= '0;
            o_hits0        <= '0;
            o_hits1        <= '0;
        end else begin
            o_count_for_rx <= (o_count_for_rx == CNT_LAST) ? 10'd0 : o_count_for_rx + 10'd1;
            if (o_count_for_rx == CNT_LATCH) begin
                o_disp_count <= i_seq_det_count;
            end
            // Frame-end clear takes priority over a coincident hit.
            if (o_count_for_rx == CNT_LAST) begin
                o_hits0 <= '0;
                o_hits1 <= '0;
            end else if (lsb_hit) begin
                if (o_active_req) begin
                    if (o_hits1 != 8'hFF) o_hits1 <= o_hits1 + 8'd1;
                end else begin
                    if (o_hits0 != 8'hFF) o_hits0 <= o_hits0 + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bday_rx_sched.sv
// tb/tb_bday_rx_sched.sv - self-checking bench for bday_rx_sched
module tb_bday_rx_sched;

    localparam int W  = 9;
    localparam int GB = 2;
    localparam int FL = 1002;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] w0, w1;
    logic       v0, v1, det;
    logic [5:0] det_cnt;
    logic       r0, r1, bit_seq, dv, busy, act;
    logic [9:0] cnt;
    logic [5:0] disp;
    logic [7:0] h0, h1;

    bday_rx_sched #(.WORD_W(W), .GAP_BITS(GB), .FRAME_LEN(FL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_word(w0), .i_req0_valid(v0), .o_req0_ready(r0),
        .i_req1_word(w1), .i_req1_valid(v1), .o_req1_ready(r1),
        .o_bit_seq(bit_seq), .o_count_for_rx(cnt),
        .i_seq_detected(det), .i_seq_det_count(det_cnt),
        .o_disp_count(disp), .o_disp_valid(dv),
        .o_hits0(h0), .o_hits1(h1), .o_busy(busy), .o_active_req(act)
    );

    // Short-word instance: a 3-cycle word period lets one frame hold more
    // than 255 detects.
    logic [0:0] s_w0 = 1'b1, s_w1 = 1'b0;
    logic       s_v0 = 1'b1, s_v1 = 1'b0, s_det = 1'b1;
    logic [5:0] s_dc = 6'd0;
    logic       s_r0, s_r1, s_bit, s_dv, s_busy, s_act;
    logic [9:0] s_cnt;
    logic [5:0] s_disp;
    logic [7:0] s_h0, s_h1;

    bday_rx_sched #(.WORD_W(1), .GAP_BITS(1), .FRAME_LEN(FL)) dut_sat (
        .i_clk(clk), .i_rst(rst),
        .i_req0_word(s_w0), .i_req0_valid(s_v0), .o_req0_ready(s_r0),
        .i_req1_word(s_w1), .i_req1_valid(s_v1), .o_req1_ready(s_r1),
        .o_bit_seq(s_bit), .o_count_for_rx(s_cnt),
        .i_seq_detected(s_det), .i_seq_det_count(s_dc),
        .o_disp_count(s_disp), .o_disp_valid(s_dv),
        .o_hits0(s_h0), .o_hits1(s_h1), .o_busy(s_busy), .o_active_req(s_act)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, actual, expected, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; det = 1'b0;
        w0 = '0; w1 = '0; det_cnt = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v0;
        logic [8:0] w0;
        logic       e_r0;
        logic       e_r1;
        logic       e_bit;
        logic       e_busy;
        int         e_cnt;
    } vec_t;

    vec_t       tab[14];
    logic [8:0] pat;

    // Behavioural reference: time-stamped transactions
    logic [8:0] mw;
    int mt, mfree, mta, mr, mlast, mdisp;
    int mh[2];

    task automatic model_reset();
        mt = 0; mfree = 0; mta = -100; mr = 0; mlast = 1; mdisp = 0;
        mh[0] = 0; mh[1] = 0;
    endtask

    int gt[$];
    int gi[$];

    initial begin
        // ---- reset state ----
        reset_dut();
        @(negedge clk);
        chk("rst_ready0", r0, 0);     chk("rst_ready1", r1, 0);
        chk("rst_bit", bit_seq, 1);   chk("rst_busy", busy, 0);
        chk("rst_active", act, 0);    chk("rst_count", cnt, 0);
        chk("rst_disp", disp, 0);     chk("rst_disp_valid", dv, 0);
        chk("rst_hits0", h0, 0);      chk("rst_hits1", h1, 0);

        // ---- table: word 0_1101_1010 from req0, word changes after accept ----
        pat = 9'h0DA;
        for (int i = 0; i < 14; i++) begin
            tab[i].v0 = 1'b1; tab[i].w0 = 9'h125;
            tab[i].e_r0 = 1'b0; tab[i].e_r1 = 1'b0;
            tab[i].e_bit = 1'b1; tab[i].e_busy = 1'b1; tab[i].e_cnt = i;
            if (i >= 1 && i <= 9) tab[i].e_bit = pat[9-i];
        end
        tab[0].w0 = 9'h0DA;  tab[0].e_r0 = 1'b1;  tab[0].e_busy = 1'b0;
        tab[12].w0 = 9'h0FF; tab[12].e_r0 = 1'b1; tab[12].e_busy = 1'b0;
        tab[13].v0 = 1'b0;   tab[13].e_bit = 1'b0;
        reset_dut();
        for (int i = 0; i < 14; i++) begin
            v0 = tab[i].v0; w0 = tab[i].w0;
            @(negedge clk);
            chk($sformatf("tab%0d_ready0", i), r0, tab[i].e_r0);
            chk($sformatf("tab%0d_ready1", i), r1, tab[i].e_r1);
            chk($sformatf("tab%0d_bit", i), bit_seq, tab[i].e_bit);
            chk($sformatf("tab%0d_busy", i), busy, tab[i].e_busy);
            chk($sformatf("tab%0d_count", i), cnt, tab[i].e_cnt);
            next();
        end

        // ---- hits on a req1 word: mid-word and gap detects ignored ----
        reset_dut();
        for (int c = 0; c <= 12; c++) begin
            v1 = (c == 0); w1 = 9'h1A5;
            det = (c == 5) || (c == 9) || (c == 11);
            @(negedge clk);
            if (c == 0) begin chk("h_ready1", r1, 1); chk("h_ready0", r0, 0); end
            if (c == 6) begin chk("h_mid_hits1", h1, 0); chk("h_mid_hits0", h0, 0); end
            if (c == 9) chk("h_active", act, 1);
            if (c == 10) begin chk("h_lsb_hits1", h1, 1); chk("h_lsb_hits0", h0, 0); end
            if (c == 12) chk("h_gap_hits1", h1, 1);
            next();
        end
        det = 1'b0;

        // ---- round robin with both requesters always valid ----
        reset_dut();
        v0 = 1'b1; v1 = 1'b1; w0 = 9'h0F0; w1 = 9'h10F;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("rr_overlap", r0 & r1, 0);
            if (r0) begin gt.push_back(c); gi.push_back(0); end
            if (r1) begin gt.push_back(c); gi.push_back(1); end
            next();
        end
        chk("rr_grants", gt.size(), 5);
        for (int k = 0; k < gt.size() && k < 5; k++) begin
            chk($sformatf("rr_time%0d", k), gt[k], 12 * k);
            chk($sformatf("rr_req%0d", k), gi[k], k % 2);
        end

        // ---- frame boundary: display latch, clear vs coincident hit, wrap ----
        reset_dut();
        w0 = 9'h1C3; w1 = 9'h0AA;
        for (int t = 0; t <= 1003; t++) begin
            v0 = (t == 980); v1 = (t == 992);
            det = (t == 989) || (t == 1001);
            det_cnt = (t == 1000) ? 6'd7 : 6'd33;
            @(negedge clk);
            if (t == 980) chk("fr_ready0", r0, 1);
            if (t == 990) chk("fr_hits0_pre", h0, 1);
            if (t == 992) chk("fr_ready1", r1, 1);
            if (t == 999) chk("fr_dv_999", dv, 0);
            if (t == 1000) begin
                chk("fr_dv_1000", dv, 1); chk("fr_cnt_1000", cnt, 1000); chk("fr_disp_1000", disp, 0);
            end
            if (t == 1001) begin
                chk("fr_dv_1001", dv, 0); chk("fr_disp_1001", disp, 7);
                chk("fr_hits0_1001", h0, 1); chk("fr_hits1_1001", h1, 0);
                chk("fr_lsb_1001", bit_seq, 0); chk("fr_busy_1001", busy, 1);
            end
            if (t == 1002) begin
                chk("fr_cnt_wrap", cnt, 0); chk("fr_hits0_clr", h0, 0); chk("fr_hits1_clr", h1, 0);
                chk("fr_busy_wrap", busy, 1); chk("fr_disp_hold", disp, 7);
            end
            if (t == 1003) chk("fr_busy_gap", busy, 1);
            next();
        end
        det = 1'b0; v0 = 1'b0; v1 = 1'b0;

        // ---- saturation on the short-word instance ----
        reset_dut();
        for (int t = 0; t <= 1002; t++) begin
            @(negedge clk);
            if (t == 301) chk("sat_hits0_301", s_h0, 100);
            if (t == 1001) begin chk("sat_hits0_255", s_h0, 255); chk("sat_hits1", s_h1, 0); end
            if (t == 1002) begin chk("sat_hits0_clr", s_h0, 0); chk("sat_cnt_wrap", s_cnt, 0); end
            next();
        end

        // ---- reset at 4th shift bit aborts the word; requester 0 first ----
        reset_dut();
        v1 = 1'b1; w1 = 9'h1FF;
        @(negedge clk);
        chk("ra_ready1", r1, 1);
        next();
        v0 = 1'b1; w0 = 9'h055;
        next(); next(); next();
        rst = 1'b1;
        @(negedge clk);
        chk("ra_rst_ready0", r0, 0); chk("ra_rst_ready1", r1, 0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("ra_bit", bit_seq, 1); chk("ra_busy", busy, 0); chk("ra_count", cnt, 0);
        chk("ra_ready0", r0, 1);   chk("ra_ready1_lo", r1, 0);
        next();
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("ra_msb", bit_seq, 0); chk("ra_active", act, 0); chk("ra_busy_shift", busy, 1);
        next();

        // ---- randomized run against the transaction-level model ----
        reset_dut();
        model_reset();
        for (int n = 0; n < 2500; n++) begin
            int  pos, g, k;
            bit  idle, any, e_r0, e_r1, e_bit;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            w0 = 9'($urandom_range(0, 511));
            w1 = 9'($urandom_range(0, 511));
            det = ($urandom_range(0, 2) == 0);
            det_cnt = 6'($urandom_range(0, 63));
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            idle = (mt >= mfree);
            pos = mt % FL;
            any = v0 || v1;
            g = (v0 && v1) ? (1 - mlast) : (v1 ? 1 : 0);
            e_r0 = !rst && idle && any && (g == 0);
            e_r1 = !rst && idle && any && (g == 1);
            k = mt - mta;
            e_bit = (!idle && k >= 1 && k <= W) ? mw[W-k] : 1'b1;
            chk("rnd_ready0", r0, e_r0);
            chk("rnd_ready1", r1, e_r1);
            chk("rnd_bit", bit_seq, e_bit);
            chk("rnd_busy", busy, !idle);
            chk("rnd_active", act, mr);
            chk("rnd_count", cnt, pos);
            chk("rnd_hits0", h0, mh[0]);
            chk("rnd_hits1", h1, mh[1]);
            chk("rnd_disp", disp, mdisp);
            chk("rnd_disp_valid", dv, pos == FL - 2);
            if (rst) begin
                model_reset();
            end else begin
                if (idle && any) begin
                    mta = mt; mw = (g == 1) ? w1 : w0; mr = g; mlast = g;
                    mfree = mt + W + GB + 1;
                end
                if (!idle && k == W && det && mh[mr] < 255) mh[mr]++;
                if (pos == FL - 1) begin mh[0] = 0; mh[1] = 0; end
                if (pos == FL - 2) mdisp = det_cnt;
                mt++;
            end
            next();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
